key_press_gen: RTL and testbench

Synthesizable key-press generator: the driving end of the push-button key interface. On a one-cycle start request it drives a key line with 1–15 clean presses, each held high for a fixed number of clock cycles and then released for a fixed gap. The hold time is long enough for the team's debounce/press-flag logic to register each press. It sits between control logic (self-test sequencer, board-to-board key emulation) and a key input pin or the key input of a press detector.

---
 rtl/key_press_gen.sv | 147 ++++++++++++++
 tb/tb_key_press_gen.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_press_gen.sv
// -----------------------------------------------------------------------------
// key_press_gen
//
// Driving end of the push-button key interface. A one-cycle start request in
// IDLE launches a burst of 1..15 clean key presses on key_out. Each press holds
// the line high for HOLD_CYCLES clocks, then releases it for GAP_CYCLES clocks.
// The hold time is sized so downstream debounce / press-flag logic registers
// every press. Typical users: self-test sequencers, board-to-board key
// emulation, or directly the key input of a press detector.
//
// Parameters
//   HOLD_CYCLES : clocks key_out stays high per press (>= 1)
//   GAP_CYCLES  : clocks key_out stays low after each press (>= 1)
//   CNT_W       : phase counter width, must hold max(HOLD,GAP)-1
//
// Ports
//   clk     in   system clock, rising edge
//   clr     in   asynchronous active-high reset; aborts any sequence at once
//   start   in   request pulse, only looked at in IDLE
//   presses in   number of presses (1..15), captured together with start
//   key_out out  generated key level (flop output, glitch free)
//   busy    out  high while a sequence runs (flop output)
//   done    out  one-cycle pulse when the last gap has elapsed (flop output)
// -----------------------------------------------------------------------------
module key_press_gen #(
   parameter int unsigned HOLD_CYCLES = 2500000,
   parameter int unsigned GAP_CYCLES  = 2500000,
   parameter int unsigned CNT_W       = 22
) (
   input  logic       clk,
   input  logic       clr,
   input  logic       start,
   input  logic [3:0] presses,
   output logic       key_out,
   output logic       busy,
   output logic       done
);

   // State encoding kept as plain constants for legacy tool compatibility.
   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_PRESS   = 2'd1;
   localparam logic [1:0] ST_RELEASE = 2'd2;

   // Terminal counts, compared against the full counter width.
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

   // ------------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------------
   logic [1:0]       state_q,     state_d;
   logic [CNT_W-1:0] cnt_q,       cnt_d;
   logic [3:0]       remaining_q, remaining_d;
   logic             key_out_q,   key_out_d;
   logic             busy_q,      busy_d;
   logic             done_q,      done_d;

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path
      // through the case can leave one unassigned and infer a latch.
      state_d     = state_q;
      cnt_d       = cnt_q;
      remaining_d = remaining_q;
      done_d      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // A zero press count is treated as "nothing to do": no busy and
            // no done, so callers cannot mistake it for a completed burst.
            if (start && (presses != 4'd0)) begin
               state_d     = ST_PRESS;
               cnt_d       = '0;
               remaining_d = presses;
            end
         end

         ST_PRESS: begin
            if (cnt_q == HOLD_LAST) begin
               state_d = ST_RELEASE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         ST_RELEASE: begin
            if (cnt_q == GAP_LAST) begin
               cnt_d = '0;
               if (remaining_q > 4'd1) begin
                  remaining_d = remaining_q - 4'd1;
                  state_d     = ST_PRESS;
               end else begin
                  // Completion lands in IDLE, so a start presented during
                  // the done cycle is accepted with no dead cycle.
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         default: begin
            // Unused encoding: recover to a clean idle.
            state_d     = ST_IDLE;
            cnt_d       = '0;
            remaining_d = '0;
         end
      endcase

      // Outputs are decoded from the next state and registered, so they
      // change on the same edge as the state and never glitch.
      key_out_d = (state_d == ST_PRESS);
      busy_d    = (state_d == ST_PRESS) || (state_d == ST_RELEASE);
   end

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         remaining_q <= '0;
         key_out_q   <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         remaining_q <= remaining_d;
         key_out_q   <= key_out_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign key_out = key_out_q;
   assign busy    = busy_q;
   assign done    = done_q;

endmodule

// File: tb/tb_key_press_gen.sv
// -----------------------------------------------------------------------------
// tb_key_press_gen
//
// Directed bench for key_press_gen. Two instances share clock and clear:
//   dut  : HOLD=4,   GAP=3   (short sequences, cycle-exact waveform checks)
//   dut2 : HOLD=300, GAP=500 (long phases measured with bench cycle counters;
//          unequal values so a swapped hold/gap is visible)
// Outputs are sampled on the falling clock edge; inputs change there too.
// -----------------------------------------------------------------------------
module tb_key_press_gen;

   logic       clk;
   logic       clr;
   logic       start;
   logic [3:0] presses;
   logic       key_out;
   logic       busy;
   logic       done;

   logic       start2;
   logic [3:0] presses2;
   logic       key_out2;
   logic       busy2;
   logic       done2;

   int checks;
   int errors;

   key_press_gen #(
      .HOLD_CYCLES (4),
      .GAP_CYCLES  (3),
      .CNT_W       (4)
   ) dut (
      .clk     (clk),
      .clr     (clr),
      .start   (start),
      .presses (presses),
      .key_out (key_out),
      .busy    (busy),
      .done    (done)
   );

   key_press_gen #(
      .HOLD_CYCLES (300),
      .GAP_CYCLES  (500),
      .CNT_W       (10)
   ) dut2 (
      .clk     (clk),
      .clr     (clr),
      .start   (start2),
      .presses (presses2),
      .key_out (key_out2),
      .busy    (busy2),
      .done    (done2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Launch a request on dut: start is high across exactly one rising edge
   // (edge k); returns at the falling edge right after edge k.
   task automatic pulse_start(input logic [3:0] n);
      @(negedge clk);
      start   = 1'b1;
      presses = n;
      @(posedge clk);
      @(negedge clk);
      start   = 1'b0;
      presses = 4'd0;
   endtask

   // ------------------------------------------------------------------------
   task automatic test_reset();
      logic [3:0] obs;
      clr = 1'b1;
      repeat (3) @(negedge clk);
      obs = {key_out, busy, done, key_out2 | busy2 | done2};
      checks++;
      if (obs !== 4'b0000) begin
         errors++;
         $display("FAIL reset_held: got %b expected 0000", obs);
      end
      clr = 1'b0;
      repeat (2) @(negedge clk);
      obs = {key_out, busy, done, key_out2 | busy2 | done2};
      checks++;
      if (obs !== 4'b0000) begin
         errors++;
         $display("FAIL reset_released: got %b expected 0000", obs);
      end
   endtask

   // ------------------------------------------------------------------------
   // presses=1: key high after edges k..k+3, busy k..k+6, done only at k+7.
   task automatic test_single_press();
      logic [2:0] obs, exp;
      pulse_start(4'd1);
      for (int i = 0; i <= 8; i++) begin
         obs = {key_out, busy, done};
         exp = {(i < 4), (i < 7), (i == 7)};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL single k+%0d: got key/busy/done=%b expected %b", i, obs, exp);
         end
         @(negedge clk);
      end
   endtask

   // ------------------------------------------------------------------------
   // presses=3: three 4-cycle pulses every 7 cycles, busy 21 cycles, one done.
   task automatic test_multi_press();
      logic [2:0] obs, exp;
      logic       prev;
      int         rises;
      int         busy_cnt;
      prev     = 1'b0;
      rises    = 0;
      busy_cnt = 0;
      pulse_start(4'd3);
      for (int i = 0; i <= 23; i++) begin
         obs = {key_out, busy, done};
         exp = {((i < 21) && ((i % 7) < 4)), (i < 21), (i == 21)};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL multi k+%0d: got key/busy/done=%b expected %b", i, obs, exp);
         end
         if (key_out && !prev) rises++;
         if (busy) busy_cnt++;
         prev = key_out;
         @(negedge clk);
      end
      checks++;
      if (rises !== 3) begin
         errors++;
         $display("FAIL multi_rises: got %0d expected 3", rises);
      end
      checks++;
      if (busy_cnt !== 21) begin
         errors++;
         $display("FAIL multi_busy_len: got %0d expected 21", busy_cnt);
      end
   endtask

   // ------------------------------------------------------------------------
   task automatic test_zero_presses();
      logic [2:0] obs;
      pulse_start(4'd0);
      for (int i = 0; i < 50; i++) begin
         obs = {key_out, busy, done};
         checks++;
         if (obs !== 3'b000) begin
            errors++;
            $display("FAIL zero_presses cyc %0d: got key/busy/done=%b expected 000", i, obs);
         end
         @(negedge clk);
      end
   endtask

   // ------------------------------------------------------------------------
   // presses=2 with a presses=5 start mid-run (ignored); then start held in
   // the done cycle launches presses=1 with key_out rising on the next edge.
   task automatic test_restart_ignored();
      logic [2:0] obs, exp;
      pulse_start(4'd2);
      for (int i = 0; i <= 14; i++) begin
         if (i == 5) begin
            start   = 1'b1;
            presses = 4'd5;
         end else if (i == 6) begin
            start   = 1'b0;
            presses = 4'd0;
         end
         obs = {key_out, busy, done};
         exp = {((i < 14) && ((i % 7) < 4)), (i < 14), (i == 14)};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL restart k+%0d: got key/busy/done=%b expected %b", i, obs, exp);
         end
         if (i == 14) begin
            start   = 1'b1;
            presses = 4'd1;
         end
         @(negedge clk);
      end
      start   = 1'b0;
      presses = 4'd0;
      for (int j = 0; j <= 8; j++) begin
         obs = {key_out, busy, done};
         exp = {(j < 4), (j < 7), (j == 7)};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL back_to_back k+%0d: got key/busy/done=%b expected %b", j, obs, exp);
         end
         @(negedge clk);
      end
   endtask

   // ------------------------------------------------------------------------
   // clr during the second press of a 4-press run: immediate drop, no done,
   // and a fresh request afterwards runs normally.
   task automatic test_clr_abort();
      logic [2:0] obs, exp;
      pulse_start(4'd4);
      for (int i = 0; i <= 8; i++) begin
         obs = {key_out, busy, done};
         exp = {((i % 7) < 4), 1'b1, 1'b0};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL pre_clr k+%0d: got key/busy/done=%b expected %b", i, obs, exp);
         end
         if (i < 8) @(negedge clk);
      end
      // Mid-way between edges: no rising edge occurs before the sample.
      clr = 1'b1;
      #1;
      obs = {key_out, busy, done};
      checks++;
      if (obs !== 3'b000) begin
         errors++;
         $display("FAIL clr_async: got key/busy/done=%b expected 000", obs);
      end
      @(negedge clk);
      clr = 1'b0;
      for (int i = 0; i < 40; i++) begin
         obs = {key_out, busy, done};
         checks++;
         if (obs !== 3'b000) begin
            errors++;
            $display("FAIL post_clr cyc %0d: got key/busy/done=%b expected 000", i, obs);
         end
         @(negedge clk);
      end
      pulse_start(4'd2);
      for (int i = 0; i <= 15; i++) begin
         obs = {key_out, busy, done};
         exp = {((i < 14) && ((i % 7) < 4)), (i < 14), (i == 14)};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL after_clr k+%0d: got key/busy/done=%b expected %b", i, obs, exp);
         end
         @(negedge clk);
      end
   endtask

   // ------------------------------------------------------------------------
   // Long phases on dut2 (HOLD=300, GAP=500), presses=2, measured by counters.
   task automatic test_long_phases();
      logic prev;
      int   rises;
      int   high_len [2];
      int   gap_len;
      int   busy_cnt;
      int   done_cnt;
      int   done_at;
      prev        = 1'b0;
      rises       = 0;
      high_len[0] = 0;
      high_len[1] = 0;
      gap_len     = 0;
      busy_cnt    = 0;
      done_cnt    = 0;
      done_at     = -1;
      @(negedge clk);
      start2   = 1'b1;
      presses2 = 4'd2;
      @(posedge clk);
      @(negedge clk);
      start2   = 1'b0;
      presses2 = 4'd0;
      for (int i = 0; i < 1700; i++) begin
         if (busy2) busy_cnt++;
         if (done2) begin
            done_cnt++;
            done_at = i;
         end
         if (key_out2) begin
            if (!prev) rises++;
            if (rises == 1 || rises == 2) high_len[rises-1]++;
         end else if (rises == 1) begin
            gap_len++;
         end
         prev = key_out2;
         @(negedge clk);
      end
      checks++;
      if (rises !== 2) begin
         errors++;
         $display("FAIL long_rises: got %0d expected 2", rises);
      end
      checks++;
      if (high_len[0] !== 300) begin
         errors++;
         $display("FAIL long_high0: got %0d expected 300", high_len[0]);
      end
      checks++;
      if (high_len[1] !== 300) begin
         errors++;
         $display("FAIL long_high1: got %0d expected 300", high_len[1]);
      end
      checks++;
      if (gap_len !== 500) begin
         errors++;
         $display("FAIL long_gap: got %0d expected 500", gap_len);
      end
      checks++;
      if (busy_cnt !== 1600) begin
         errors++;
         $display("FAIL long_busy_len: got %0d expected 1600", busy_cnt);
      end
      checks++;
      if (done_cnt !== 1 || done_at !== 1600) begin
         errors++;
         $display("FAIL long_done: got count %0d at k+%0d expected 1 at k+1600", done_cnt, done_at);
      end
   endtask

   // ------------------------------------------------------------------------
   initial begin
      checks   = 0;
      errors   = 0;
      clr      = 1'b1;
      start    = 1'b0;
      presses  = 4'd0;
      start2   = 1'b0;
      presses2 = 4'd0;
      test_reset();
      test_single_press();
      test_multi_press();
      test_zero_presses();
      test_restart_ignored();
      test_clr_abort();
      test_long_phases();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
